fp8_twiddle_gen: RTL and testbench



---
 rtl/fp8_twiddle_gen.sv | 199 +++++++++++++++++++
 tb/tb_fp8_twiddle_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_twiddle_gen.sv
// FP8 E4M3 twiddle-factor stream for a radix-2 DIT FFT: walks every stage/butterfly of one frame,
// deriving W_N^k from a quarter-wave cosine ROM with quadrant symmetry and optional conjugation.
module fp8_twiddle_gen #(
    parameter int LOG2N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    input  logic             tw_ready,
    output logic             busy,
    output logic             tw_valid,
    output logic [7:0]       tw_re,
    output logic [7:0]       tw_im,
    output logic [2:0]       tw_stage,
    output logic [LOG2N-2:0] tw_bfly,
    output logic [LOG2N-1:0] tw_k,
    output logic             tw_last
);

    localparam int             N     = 1 << LOG2N;
    localparam int             BW    = LOG2N - 1;
    localparam logic [BW-1:0]  B_MAX = BW'(N / 2 - 1);
    localparam logic [BW-1:0]  Q_IDX = BW'(N / 4);
    localparam logic [2:0]     S_MAX = 3'(LOG2N - 1);

    if (LOG2N < 3 || LOG2N > 5) begin : g_bad_log2n
        $error("fp8_twiddle_gen: LOG2N must be 3, 4 or 5");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // cos(2*pi*i/N) for i = 0..N/4, E4M3 round-to-nearest
    function automatic logic [7:0] rom(input logic [BW-1:0] i);
        logic [7:0] c;
        c = 8'h00;
        if (LOG2N == 3) begin
            case (int'(i))
                0:       c = 8'h38;
                1:       c = 8'h33;
                default: c = 8'h00;
            endcase
        end else if (LOG2N == 4) begin
            case (int'(i))
                0:       c = 8'h38;
                1:       c = 8'h37;
                2:       c = 8'h33;
                3:       c = 8'h2C;
                default: c = 8'h00;
            endcase
        end else begin
            case (int'(i))
                0:       c = 8'h38;
                1:       c = 8'h38;
                2:       c = 8'h37;
                3:       c = 8'h35;
                4:       c = 8'h33;
                5:       c = 8'h31;
                6:       c = 8'h2C;
                7:       c = 8'h24;
                default: c = 8'h00;
            endcase
        end
        return c;
    endfunction

    // Zero keeps its +0 encoding so 0x80 never appears on the bus
    function automatic logic [7:0] neg8(input logic [7:0] x);
        return (x == 8'h00) ? 8'h00 : {~x[7], x[6:0]};
    endfunction

    state_t           state_q, state_d;
    logic             inv_q, inv_d;
    logic [2:0]       s_q, s_d;
    logic [BW-1:0]    b_q, b_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [7:0]       re_q, re_d;
    logic [7:0]       im_q, im_d;
    logic [LOG2N-1:0] k_q, k_d;

    logic             load;
    logic [BW-1:0]    b_masked;
    logic [LOG2N-1:0] k_next;
    logic [1:0]       quad;
    logic [BW-1:0]    r_idx;
    logic [BW-1:0]    qr_idx;
    logic [7:0]       c_r;
    logic [7:0]       c_qr;
    logic [7:0]       re_n;
    logic [7:0]       im_n;

    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        s_d     = s_q;
        b_d     = b_q;
        valid_d = valid_q;
        last_d  = last_q;
        re_d    = re_q;
        im_d    = im_q;
        k_d     = k_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    inv_d   = inverse;
                    s_d     = 3'd0;
                    b_d     = '0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (valid_q && tw_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        load = 1'b1;
                        if (b_q == B_MAX) begin
                            b_d = '0;
                            s_d = s_q + 3'd1;
                        end else begin
                            b_d = b_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // k = (b mod 2^s) * 2^(LOG2N-1-s), then fold onto the quarter-wave table
        b_masked = b_d & BW'((1 << s_d) - 1);
        k_next   = LOG2N'(b_masked) << (S_MAX - s_d);
        quad     = k_next[LOG2N-1 -: 2];
        r_idx    = {1'b0, k_next[LOG2N-3:0]};
        qr_idx   = Q_IDX - r_idx;
        c_r      = rom(r_idx);
        c_qr     = rom(qr_idx);

        case (quad)
            2'd0:    begin re_n = c_r;        im_n = neg8(c_qr); end
            2'd1:    begin re_n = neg8(c_qr); im_n = neg8(c_r);  end
            2'd2:    begin re_n = neg8(c_r);  im_n = c_qr;       end
            default: begin re_n = c_qr;       im_n = c_r;        end
        endcase
        if (inv_d) begin
            im_n = neg8(im_n);
        end

        if (load) begin
            valid_d = 1'b1;
            last_d  = (s_d == S_MAX) && (b_d == B_MAX);
            re_d    = re_n;
            im_d    = im_n;
            k_d     = k_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            inv_q   <= 1'b0;
            s_q     <= 3'd0;
            b_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            re_q    <= 8'h00;
            im_q    <= 8'h00;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            s_q     <= s_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            re_q    <= re_d;
            im_q    <= im_d;
            k_q     <= k_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign tw_valid = valid_q;
    assign tw_last  = last_q;
    assign tw_re    = re_q;
    assign tw_im    = im_q;
    assign tw_stage = s_q;
    assign tw_bfly  = b_q;
    assign tw_k     = k_q;

endmodule

// File: tb/tb_fp8_twiddle_gen.sv
// Bench for fp8_twiddle_gen (LOG2N=4): scoreboard of expected frame words plus table of spot vectors.
module tb_fp8_twiddle_gen;

    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int WORDS = LOG2N * N / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       inverse = 1'b0;
    logic       tw_ready = 1'b1;
    logic       busy;
    logic       tw_valid;
    logic [7:0] tw_re;
    logic [7:0] tw_im;
    logic [2:0] tw_stage;
    logic [2:0] tw_bfly;
    logic [3:0] tw_k;
    logic       tw_last;

    fp8_twiddle_gen #(.LOG2N(LOG2N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .inverse  (inverse),
        .tw_ready (tw_ready),
        .busy     (busy),
        .tw_valid (tw_valid),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .tw_stage (tw_stage),
        .tw_bfly  (tw_bfly),
        .tw_k     (tw_k),
        .tw_last  (tw_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] s;
        logic [2:0] b;
        logic [3:0] k;
        logic [7:0] re;
        logic [7:0] im;
        logic       last;
    } word_t;

    typedef struct {
        int         s;
        int         b;
        logic       inv;
        logic [3:0] k;
        logic [7:0] re;
        logic [7:0] im;
    } spot_t;

    int checks = 0;
    int errors = 0;
    word_t exp_q[$];
    logic [7:0] tab_re[8];
    logic [7:0] tab_im[8];
    logic [7:0] seen_re[4][8];
    logic [7:0] seen_im[4][8];
    logic [3:0] seen_k[4][8];
    spot_t spots[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t model(input int s, input int b, input logic inv);
        word_t w;
        int k;
        k      = (b % (1 << s)) * (N >> (s + 1));
        w.s    = 3'(s);
        w.b    = 3'(b);
        w.k    = 4'(k);
        w.re   = tab_re[k];
        w.im   = tab_im[k];
        if (inv && w.im != 8'h00) w.im = w.im ^ 8'h80;
        w.last = (s == LOG2N - 1) && (b == N / 2 - 1);
        return w;
    endfunction

    function automatic logic [31:0] pack_out();
        return {5'd0, tw_stage, tw_bfly, tw_k, tw_re, tw_im, tw_last};
    endfunction

    function automatic logic [31:0] pack_w(input word_t w);
        return {5'd0, w.s, w.b, w.k, w.re, w.im, w.last};
    endfunction

    // stall_at/stall_len: hold ready low; disturb: pulse start and flip inverse mid-frame; rst_at: abort
    task automatic run_frame(input logic inv, input int stall_at, input int stall_len,
                             input logic disturb, input int rst_at);
        int cnt;
        int stalled;
        int guard;
        word_t e;
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++)
            for (int b = 0; b < N / 2; b++)
                exp_q.push_back(model(s, b, inv));
        inverse  = inv;
        start    = 1'b1;
        tw_ready = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_busy_valid", {busy, tw_valid}, 2'b11);
        cnt = 0;
        stalled = 0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            guard++;
            if (disturb) begin
                start   = (cnt == 5);
                inverse = (cnt >= 3) ? ~inv : inv;
            end
            if (rst_at >= 0 && cnt == rst_at) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                chk("rst_mid_valid_busy", {tw_valid, busy, tw_last}, 3'b000);
                chk("rst_mid_outputs", pack_out(), 32'd0);
                exp_q.delete();
                return;
            end
            tw_ready = !(cnt == stall_at && stalled < stall_len);
            if (!tw_valid) begin
                chk("valid_dropped", 32'(tw_valid), 32'd1);
            end else if (!tw_ready) begin
                stalled++;
                chk("stall_hold", pack_out(), pack_w(exp_q[0]));
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("word%0d", cnt), pack_out(), pack_w(e));
                chk("no_0x80", 32'((tw_re == 8'h80) || (tw_im == 8'h80)), 32'd0);
                seen_re[tw_stage % 4][tw_bfly] = tw_re;
                seen_im[tw_stage % 4][tw_bfly] = tw_im;
                seen_k[tw_stage % 4][tw_bfly]  = tw_k;
                cnt++;
            end
            cycle();
        end
        start    = 1'b0;
        inverse  = 1'b0;
        tw_ready = 1'b1;
        chk("frame_words", 32'(cnt), 32'(WORDS));
        chk("frame_end_idle", {tw_valid, busy}, 2'b00);
        if (stall_len > 0) chk("stall_cycles", 32'(stalled), 32'(stall_len));
    endtask

    task automatic check_spots(input logic inv);
        for (int i = 0; i < 7; i++) begin
            if (spots[i].inv == inv) begin
                chk($sformatf("spot_k s%0d b%0d", spots[i].s, spots[i].b),
                    32'(seen_k[spots[i].s][spots[i].b]), 32'(spots[i].k));
                chk($sformatf("spot_reim s%0d b%0d inv%0d", spots[i].s, spots[i].b, inv),
                    {seen_re[spots[i].s][spots[i].b], seen_im[spots[i].s][spots[i].b]},
                    {spots[i].re, spots[i].im});
            end
        end
    endtask

    initial begin
        // W_16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in E4M3, k = 0..7
        tab_re = '{8'h38, 8'h37, 8'h33, 8'h2C, 8'h00, 8'hAC, 8'hB3, 8'hB7};
        tab_im = '{8'h00, 8'hAC, 8'hB3, 8'hB7, 8'hB8, 8'hB7, 8'hB3, 8'hAC};
        spots[0] = '{s: 3, b: 2, inv: 1'b0, k: 4'd2, re: 8'h33, im: 8'hB3};
        spots[1] = '{s: 3, b: 5, inv: 1'b0, k: 4'd5, re: 8'hAC, im: 8'hB7};
        spots[2] = '{s: 3, b: 6, inv: 1'b0, k: 4'd6, re: 8'hB3, im: 8'hB3};
        spots[3] = '{s: 1, b: 1, inv: 1'b0, k: 4'd4, re: 8'h00, im: 8'hB8};
        spots[4] = '{s: 3, b: 2, inv: 1'b1, k: 4'd2, re: 8'h33, im: 8'h33};
        spots[5] = '{s: 1, b: 1, inv: 1'b1, k: 4'd4, re: 8'h00, im: 8'h38};
        spots[6] = '{s: 0, b: 0, inv: 1'b1, k: 4'd0, re: 8'h38, im: 8'h00};

        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_ctrl", {busy, tw_valid, tw_last}, 3'b000);
        chk("reset_data", pack_out(), 32'd0);
        rst = 1'b0;
        cycle();
        chk("idle_no_start", {busy, tw_valid}, 2'b00);

        run_frame(1'b0, -1, 0, 1'b0, -1);
        check_spots(1'b0);
        cycle();
        chk("idle_after_frame", {busy, tw_valid}, 2'b00);

        run_frame(1'b1, -1, 0, 1'b0, -1);
        check_spots(1'b1);

        run_frame(1'b0, 12, 3, 1'b0, -1);
        run_frame(1'b0, -1, 0, 1'b1, -1);
        run_frame(1'b1, -1, 0, 1'b1, -1);

        run_frame(1'b0, -1, 0, 1'b0, 10);
        cycle();
        chk("after_rst_idle", {busy, tw_valid}, 2'b00);
        run_frame(1'b0, -1, 0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
